alu_warp_max_unit: RTL
======================

Name: alu_warp_max_unit

Overview:
- Multi-cycle reduction unit directly downstream of the ALU request interface. It consumes requests that the ALU dispatch has steered to it because their is_max flag is set.
- Computes the maximum of rs1_data across the active threads of the warp, signed or unsigned. Broadcasts the result to every thread lane on an ALU-style commit port.
- Scans LANES threads per cycle, so it is iterative rather than combinational.

Parameters:
- NUM_THREADS, 4, threads per warp; must be a power of 2.
- LANES, 1, threads compared per scan cycle; must divide NUM_THREADS.
- UUID_BITS, 44, instruction UUID width.
- NW_BITS, 2, warp id width.
- NR_BITS, 5, register id width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  unit can accept a request
- req_uuid  in  UUID_BITS  instruction uuid
- req_wid  in  NW_BITS  warp id
- req_tmask  in  NUM_THREADS  active thread mask
- req_PC  in  32  instruction PC
- req_op_mod  in  2  bit0: 1=signed, 0=unsigned; bit1 reserved, ignored
- req_rs1_data  in  NUM_THREADS*32  per-thread operand
- req_rd  in  NR_BITS  destination register
- req_wb  in  1  writeback enable
- commit_valid  out  1  result valid
- commit_ready  in  1  consumer accepts result
- commit_uuid, commit_wid, commit_tmask, commit_PC, commit_rd, commit_wb  out  same widths as the req_ fields  latched copies of the request fields
- commit_data  out  NUM_THREADS*32  max value replicated in every lane

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, named reset. While reset=0: state=IDLE, req_ready=0, commit_valid=0, all latched fields, accumulator and index cleared to 0. The first cycle after release has req_ready=1.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - req_ready=1, commit_valid=0.
  - On req_valid&req_ready: latch all request fields, including rs1_data.
  - acc <= 0x80000000 if signed, else 0x00000000.
  - found <= 0; idx <= 0; best_tid <= 0; go to SCAN.
- SCAN:
  - req_ready=0.
  - Each cycle, examine threads idx .. idx+LANES-1 in ascending order.
  - For each thread t with tmask[t]=1: if found=0, or value > acc (strict compare, signed or unsigned per latched op_mod[0]), then acc <= value, best_tid <= t, found <= 1.
  - Within one cycle the lanes chain combinationally, lowest index first, so ties resolve to the lowest tid.
  - idx <= idx+LANES. When the group just processed is the last one (idx+LANES == NUM_THREADS), go to DONE.
- DONE:
  - commit_valid=1.
  - commit_data lanes all = acc if found=1, else all 0.
  - All commit_ fields are stable while commit_valid=1 and commit_ready=0.
  - On commit_ready, go to IDLE.
- Latency: accept on edge E0. commit_valid is asserted after edge E0+NUM_THREADS/LANES.
- Minimum issue interval: NUM_THREADS/LANES+2 cycles. A new request is accepted only in IDLE; there is no back-to-back DONE-to-SCAN transition.
- Zero tmask: the full scan length is still executed. Result is 0 in all lanes; commit_tmask=0.
- Upstream changes to req_* after acceptance have no effect, because all operands are latched.
- Reset asserted mid-SCAN or mid-DONE: the in-flight request is discarded and commit_valid drops immediately (asynchronously).
- idx width: log2(NUM_THREADS)+1 bits, so it never wraps before the terminal compare.

Optional Feature:
- Macro: ALU_MAX_ARGMAX_EN.
- When defined:
  - Adds output port commit_argmax, width max(1,log2(NUM_THREADS)): best_tid of the winning thread, with ties going to the lowest tid.
  - commit_argmax is 0 when found=0.
  - In DONE, commit_data lane best_tid carries acc and all other lanes carry 0, giving a one-hot lane result.
- When undefined: the port is absent, best_tid logic is removed, and acc is broadcast to all lanes.

Test Plan:
- NUM_THREADS=4, LANES=1, signed, tmask=1111, rs1={t0=5,t1=0xFFFFFFFD,t2=7,t3=7}, accept at E0 -> commit_valid after E4; all lanes 7; argmax (if enabled) = 2.
- Same operands, unsigned -> all lanes 0xFFFFFFFD; argmax=1.
- tmask=0101, signed, rs1={0x80000000,100,0x80000000,9} -> the 100 in inactive t1 is ignored; result 0x80000000 (t0 wins the tie over t2); argmax=0.
- tmask=0000 -> commit_valid after E4; data all 0; commit_tmask=0.
- Hold commit_ready=0 for 3 cycles in DONE -> all commit_ outputs stable; req_ready=0 throughout; after the commit_ready pulse, req_ready=1 next cycle.
- LANES=2, tmask=1111, rs1={1,9,9,3} -> commit_valid after E2; result 9; argmax=1. Repeat the scenario and drive reset=0 after E1 -> commit_valid stays 0, req_ready=0 during reset, req_ready=1 after release.

Source files
------------

// File: rtl/alu_warp_max_unit.sv
// Iterative warp-wide max reduction (signed/unsigned) that scans LANES threads per cycle.
// Optional ALU_MAX_ARGMAX_EN: adds commit_argmax and a one-hot lane result.
module alu_warp_max_unit #(
    parameter int NUM_THREADS = 4,
    parameter int LANES       = 1,
    parameter int UUID_BITS   = 44,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [UUID_BITS-1:0]          req_uuid,
    input  logic [NW_BITS-1:0]            req_wid,
    input  logic [NUM_THREADS-1:0]        req_tmask,
    input  logic [31:0]                   req_PC,
    input  logic [1:0]                    req_op_mod,
    input  logic [NUM_THREADS*32-1:0]     req_rs1_data,
    input  logic [NR_BITS-1:0]            req_rd,
    input  logic                          req_wb,
    output logic                          commit_valid,
    input  logic                          commit_ready,
    output logic [UUID_BITS-1:0]          commit_uuid,
    output logic [NW_BITS-1:0]            commit_wid,
    output logic [NUM_THREADS-1:0]        commit_tmask,
    output logic [31:0]                   commit_PC,
    output logic [NR_BITS-1:0]            commit_rd,
    output logic                          commit_wb,
`ifdef ALU_MAX_ARGMAX_EN
    output logic [((NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1)-1:0] commit_argmax,
`endif
    output logic [NUM_THREADS*32-1:0]     commit_data
);

    localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int IDX_W = $clog2(NUM_THREADS) + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 r_state;
    logic                   r_cvalid;
    logic [UUID_BITS-1:0]   r_uuid;
    logic [NW_BITS-1:0]     r_wid;
    logic [NUM_THREADS-1:0] r_tmask;
    logic [31:0]            r_pc;
    logic                   r_signed;
    logic [31:0]            r_rs1 [NUM_THREADS];
    logic [NR_BITS-1:0]     r_rd;
    logic                   r_wb;
    logic [31:0]            r_acc;
    logic                   r_found;
    logic [IDX_W-1:0]       r_idx;
`ifdef ALU_MAX_ARGMAX_EN
    logic [TID_W-1:0]       r_best;
    logic [TID_W-1:0]       w_best;
`endif

    logic [31:0]            w_acc;
    logic                   w_found;
    logic [TID_W-1:0]       w_tid;
    logic                   w_last;
    logic                   w_unused_opmod;

    assign w_unused_opmod = req_op_mod[1];

    function automatic logic f_gt(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        if (sgn)
            return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // Lanes chain lowest index first so a tie keeps the earlier thread.
    always_comb begin
        w_acc   = r_acc;
        w_found = r_found;
        w_tid   = '0;
`ifdef ALU_MAX_ARGMAX_EN
        w_best  = r_best;
`endif
        for (int l = 0; l < LANES; l++) begin
            w_tid = TID_W'(r_idx) + TID_W'(l);
            if (r_tmask[w_tid] && (!w_found || f_gt(r_rs1[w_tid], w_acc, r_signed))) begin
                w_acc   = r_rs1[w_tid];
                w_found = 1'b1;
`ifdef ALU_MAX_ARGMAX_EN
                w_best  = w_tid;
`endif
            end
        end
    end

    assign w_last = (r_idx + IDX_W'(LANES)) == IDX_W'(NUM_THREADS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cvalid <= 1'b0;
            r_uuid   <= '0;
            r_wid    <= '0;
            r_tmask  <= '0;
            r_pc     <= '0;
            r_signed <= 1'b0;
            r_rd     <= '0;
            r_wb     <= 1'b0;
            r_acc    <= '0;
            r_found  <= 1'b0;
            r_idx    <= '0;
`ifdef ALU_MAX_ARGMAX_EN
            r_best   <= '0;
`endif
            for (int t = 0; t < NUM_THREADS; t++)
                r_rs1[t] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cvalid <= 1'b0;
                    if (req_valid) begin
                        r_uuid   <= req_uuid;
                        r_wid    <= req_wid;
                        r_tmask  <= req_tmask;
                        r_pc     <= req_PC;
                        r_signed <= req_op_mod[0];
                        r_rd     <= req_rd;
                        r_wb     <= req_wb;
                        for (int t = 0; t < NUM_THREADS; t++)
                            r_rs1[t] <= req_rs1_data[t*32 +: 32];
                        r_acc    <= req_op_mod[0] ? 32'h8000_0000 : 32'h0000_0000;
                        r_found  <= 1'b0;
                        r_idx    <= '0;
`ifdef ALU_MAX_ARGMAX_EN
                        r_best   <= '0;
`endif
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    r_acc   <= w_acc;
                    r_found <= w_found;
`ifdef ALU_MAX_ARGMAX_EN
                    r_best  <= w_best;
`endif
                    r_idx   <= r_idx + IDX_W'(LANES);
                    if (w_last) begin
                        r_state  <= DONE;
                        r_cvalid <= 1'b1;
                    end
                end
                DONE: begin
                    if (commit_ready) begin
                        r_state  <= IDLE;
                        r_cvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_cvalid <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates ready so it is low while held and high as soon as it releases.
    assign req_ready    = reset && (r_state == IDLE);
    assign commit_valid = r_cvalid;
    assign commit_uuid  = r_uuid;
    assign commit_wid   = r_wid;
    assign commit_tmask = r_tmask;
    assign commit_PC    = r_pc;
    assign commit_rd    = r_rd;
    assign commit_wb    = r_wb;

`ifdef ALU_MAX_ARGMAX_EN
    assign commit_argmax = r_found ? r_best : '0;
`endif

    always_comb begin
        commit_data = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
`ifdef ALU_MAX_ARGMAX_EN
            if (r_found && (TID_W'(t) == r_best))
                commit_data[t*32 +: 32] = r_acc;
`else
            if (r_found)
                commit_data[t*32 +: 32] = r_acc;
`endif
        end
    end

endmodule
